// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets and handshake state encoding.
package gpio_pkg;

  localparam logic [31:0] GPIO_OUT        = 32'h00;
  localparam logic [31:0] GPIO_IN         = 32'h01;
  localparam logic [31:0] GPIO_IO_DIR     = 32'h02;
  localparam logic [31:0] GPIO_IO_IN      = 32'h03;
  localparam logic [31:0] GPIO_IO_OUT     = 32'h04;
  localparam logic [31:0] GPIO_IO_SET     = 32'h05;
  localparam logic [31:0] GPIO_IO_CLR     = 32'h06;
  localparam logic [31:0] GPIO_IO_TGL     = 32'h07;
  localparam logic [31:0] GPIO_RISE_EN    = 32'h08;
  localparam logic [31:0] GPIO_FALL_EN    = 32'h09;
  localparam logic [31:0] GPIO_IRQ_STATUS = 32'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } hs_state_e;

endpackage

// File: rtl/gpio_input_sync.sv
// Multi-flop synchroniser for asynchronous pins followed by an edge-history register.
// Masked bits are treated as 0 in the edge vector, so unmasking a high pin yields a rise.
module gpio_input_sync #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             prev_q, prev_d;
  logic [WIDTH-1:0]             edge_vec;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_val = sync_q[STAGES-1];
    edge_vec = sync_q[STAGES-1] & ~mask;
    prev_d   = edge_vec;
    rise     = edge_vec & ~prev_q;
    fall     = ~edge_vec & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// Bus-attached GPIO peripheral: output, input and bidirectional pins, atomic IO set/clear/toggle,
// synchronised edge capture into a write-one-to-clear status register and a level interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 6,
  parameter int NUM_IO      = 5,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] inputs,
  output logic [NUM_OUT-1:0] outputs,
  input  logic [NUM_IO-1:0] io_inputs,
  output logic [NUM_IO-1:0] io_outputs,
  output logic [NUM_IO-1:0] io_direction,
  input  logic [ADDR_W-1:0] target_address,
  input  logic              is_write,
  input  logic [31:0]       write_value,
  input  logic              start_request,
  output logic              request_done,
  output logic [31:0]       fetched_value,
  output logic              irq
);

  localparam int EW = NUM_IN + NUM_IO;

  hs_state_e          state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [NUM_IO-1:0]  io_dir_q, io_dir_d;
  logic [NUM_IO-1:0]  io_out_q, io_out_d;
  logic [EW-1:0]      rise_en_q, rise_en_d;
  logic [EW-1:0]      fall_en_q, fall_en_d;
  logic [EW-1:0]      irq_status_q, irq_status_d;
  logic [31:0]        fetched_q, fetched_d;
  logic               irq_q, irq_d;

  logic [EW-1:0]      sync_val, rise, fall, edge_mask, edge_set, w1c;
  logic [NUM_IN-1:0]  sync_in;
  logic [NUM_IO-1:0]  sync_io;
  logic [31:0]        addr_ext, read_data;
  logic               access;

  // Pins configured as outputs are hidden from the edge detector.
  assign edge_mask = {io_dir_q, {NUM_IN{1'b0}}};

  gpio_input_sync #(
    .WIDTH  (EW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .din      ({io_inputs, inputs}),
    .mask     (edge_mask),
    .sync_val (sync_val),
    .rise     (rise),
    .fall     (fall)
  );

  assign sync_in  = sync_val[NUM_IN-1:0];
  assign sync_io  = sync_val[EW-1:NUM_IN];
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign addr_ext = 32'(target_address);
  assign access   = (state_q == ST_IDLE) && start_request;

  always_comb begin
    read_data = 32'h0;
    case (addr_ext)
      GPIO_OUT:        read_data = 32'(out_q);
      GPIO_IN:         read_data = 32'(sync_in);
      GPIO_IO_DIR:     read_data = 32'(io_dir_q);
      GPIO_IO_IN:      read_data = 32'(sync_io & ~io_dir_q);
      GPIO_IO_OUT:     read_data = 32'(io_out_q);
      GPIO_RISE_EN:    read_data = 32'(rise_en_q);
      GPIO_FALL_EN:    read_data = 32'(fall_en_q);
      GPIO_IRQ_STATUS: read_data = 32'(irq_status_q);
      default:         read_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    io_dir_d  = io_dir_q;
    io_out_d  = io_out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    fetched_d = fetched_q;
    w1c       = '0;

    case (state_q)
      ST_IDLE: if (start_request) state_d = ST_DONE;
      ST_DONE: if (!start_request) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (access && is_write) begin
      case (addr_ext)
        GPIO_OUT:        out_d     = NUM_OUT'(write_value);
        GPIO_IO_DIR:     io_dir_d  = NUM_IO'(write_value);
        GPIO_IO_OUT:     io_out_d  = NUM_IO'(write_value);
        GPIO_IO_SET:     io_out_d  = NUM_IO'(32'(io_out_q) | write_value);
        GPIO_IO_CLR:     io_out_d  = NUM_IO'(32'(io_out_q) & ~write_value);
        GPIO_IO_TGL:     io_out_d  = NUM_IO'(32'(io_out_q) ^ write_value);
        GPIO_RISE_EN:    rise_en_d = EW'(write_value);
        GPIO_FALL_EN:    fall_en_d = EW'(write_value);
        GPIO_IRQ_STATUS: w1c       = EW'(write_value);
        default:         ;
      endcase
    end

    if (access) fetched_d = is_write ? 32'h0 : read_data;

    // A fresh edge beats a same-cycle clear so no event is ever lost.
    irq_status_d = (irq_status_q & ~w1c) | edge_set;
    irq_d        = |irq_status_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      io_dir_q     <= '0;
      io_out_q     <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      fetched_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      io_dir_q     <= io_dir_d;
      io_out_q     <= io_out_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      fetched_q    <= fetched_d;
      irq_q        <= irq_d;
    end
  end

  assign outputs       = out_q;
  assign io_outputs    = io_out_q;
  assign io_direction  = io_dir_q;
  assign request_done  = (state_q == ST_DONE);
  assign fetched_value = fetched_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank: register map, atomic IO ops, handshake,
// edge capture/interrupt timing and reset behaviour.
module tb_gpio_bank;

  localparam int NUM_OUT = 4;
  localparam int NUM_IN  = 6;
  localparam int NUM_IO  = 5;
  localparam int ADDR_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_IN-1:0]  inputs;
  logic [NUM_OUT-1:0] outputs;
  logic [NUM_IO-1:0]  io_inputs;
  logic [NUM_IO-1:0]  io_outputs;
  logic [NUM_IO-1:0]  io_direction;
  logic [ADDR_W-1:0]  target_address;
  logic               is_write;
  logic [31:0]        write_value;
  logic               start_request;
  logic               request_done;
  logic [31:0]        fetched_value;
  logic               irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_bank #(
    .NUM_OUT     (NUM_OUT),
    .NUM_IN      (NUM_IN),
    .NUM_IO      (NUM_IO),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inputs         (inputs),
    .outputs        (outputs),
    .io_inputs      (io_inputs),
    .io_outputs     (io_outputs),
    .io_direction   (io_direction),
    .target_address (target_address),
    .is_write       (is_write),
    .write_value    (write_value),
    .start_request  (start_request),
    .request_done   (request_done),
    .fetched_value  (fetched_value),
    .irq            (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] r);
    logic got;
    got            = 1'b0;
    target_address = a;
    is_write       = w;
    write_value    = d;
    start_request  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (request_done) begin
        got = 1'b1;
        break;
      end
    end
    r = fetched_value;
    check("handshake_done", 32'(got), 32'h1);
    start_request = 1'b0;
    cycles(1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 1'b0, 32'h0, r);
    check(tag, r, exp);
  endtask

  // Holds start_request for several cycles on one write and checks done timing.
  task automatic hold_write(input string tag, input logic [7:0] a, input logic [31:0] d);
    target_address = a;
    is_write       = 1'b1;
    write_value    = d;
    start_request  = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      cycles(1);
      check($sformatf("%s_done_c%0d", tag, c), 32'(request_done), 32'h1);
    end
    start_request = 1'b0;
    cycles(1);
    check({tag, "_done_low"}, 32'(request_done), 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    inputs         = '0;
    io_inputs      = '0;
    target_address = '0;
    is_write       = 1'b0;
    write_value    = '0;
    start_request  = 1'b0;
    cycles(3);
    check("rst_done", 32'(request_done), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_outputs", 32'(outputs), 32'h0);
    check("rst_io_outputs", 32'(io_outputs), 32'h0);
    check("rst_io_direction", 32'(io_direction), 32'h0);
    rst = 1'b0;
    cycles(1);
    for (int a = 0; a <= 10; a++) begin
      rd_chk($sformatf("rst_rd_%0h", a), 8'(a), 32'h0);
    end

    // OUT truncation and IO atomic ops
    wr(8'h00, 32'hFF);
    check("out_trunc_pins", 32'(outputs), 32'h0F);
    rd_chk("out_trunc_rd", 8'h00, 32'h0F);
    wr(8'h04, 32'h1F);
    wr(8'h06, 32'h05);
    check("io_clr", 32'(io_outputs), 32'h1A);
    wr(8'h07, 32'h03);
    check("io_tgl", 32'(io_outputs), 32'h19);
    rd_chk("io_out_rd", 8'h04, 32'h19);
    rd_chk("io_set_wo_rd", 8'h05, 32'h0);

    // Held requests perform exactly one access
    hold_write("hold_tgl", 8'h07, 32'h01);
    check("hold_tgl_once", 32'(io_outputs), 32'h18);
    hold_write("hold_set", 8'h05, 32'h01);
    check("hold_set_once", 32'(io_outputs), 32'h19);

    // Rising edge on inputs[0]
    wr(8'h08, 32'h01);
    inputs = 6'h01;
    cycles(1);
    check("rise_irq_c1", 32'(irq), 32'h0);
    cycles(1);
    check("rise_irq_c2", 32'(irq), 32'h0);
    cycles(1);
    check("rise_irq_c3", 32'(irq), 32'h0);
    cycles(1);
    check("rise_irq_c4", 32'(irq), 32'h1);
    rd_chk("rise_status", 8'h0A, 32'h001);
    wr(8'h0A, 32'h01);
    check("w1c_irq", 32'(irq), 32'h0);
    rd_chk("w1c_status", 8'h0A, 32'h0);

    // Direction masking and edge after direction change
    wr(8'h02, 32'h01);
    check("io_dir_pins", 32'(io_direction), 32'h01);
    io_inputs = 5'h1F;
    cycles(3);
    rd_chk("io_in_masked", 8'h03, 32'h1E);
    rd_chk("in_rd", 8'h01, 32'h01);
    wr(8'h09, 32'h40);
    wr(8'h02, 32'h00);
    cycles(3);
    rd_chk("dir_change_no_rise_irq", 8'h0A, 32'h0);
    io_inputs = 5'h1E;
    cycles(4);
    check("fall_irq", 32'(irq), 32'h1);
    rd_chk("fall_status", 8'h0A, 32'h40);
    wr(8'h0A, 32'h40);
    rd_chk("io_in_unmasked", 8'h03, 32'h1E);

    // Same-cycle edge and W1C: set wins
    inputs = 6'h00;
    cycles(4);
    rd_chk("pre_race_status", 8'h0A, 32'h0);
    inputs = 6'h01;
    cycles(2);
    wr(8'h0A, 32'h01);
    rd_chk("race_status", 8'h0A, 32'h01);
    check("race_irq", 32'(irq), 32'h1);
    wr(8'h0A, 32'h01);
    rd_chk("race_cleared", 8'h0A, 32'h0);

    // Reset in the middle of a request
    target_address = 8'h00;
    is_write       = 1'b1;
    write_value    = 32'h0F;
    start_request  = 1'b1;
    cycles(1);
    check("mid_done_before_rst", 32'(request_done), 32'h1);
    check("mid_out_written", 32'(outputs), 32'h0F);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_done", 32'(request_done), 32'h0);
    check("mid_rst_outputs", 32'(outputs), 32'h0);
    check("mid_rst_io_outputs", 32'(io_outputs), 32'h0);
    start_request = 1'b0;
    rst           = 1'b0;
    cycles(3);
    wr(8'h00, 32'h05);
    check("post_rst_out", 32'(outputs), 32'h05);
    rd_chk("post_rst_out_rd", 8'h00, 32'h05);
    rd_chk("post_rst_in_rd", 8'h01, 32'h01);
    rd_chk("post_rst_rise_en", 8'h08, 32'h0);
    wr(8'h0B, 32'hFF);
    rd_chk("unmapped_rd", 8'h0B, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
